// File: rtl/mram_host_pkg.sv
// mram_host_pkg: shared op codes, FSM state encoding and default widths for the MRAM serial host
package mram_host_pkg;
  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  localparam int RD_LAT_DEF = 4;
  localparam int GAP_CYC_DEF = 2;
  localparam logic [2:0] SEL_IDLE = 3'b000;
  localparam logic [2:0] SEL_WRITE = 3'b011;
  localparam logic [2:0] SEL_READ = 3'b010;
  typedef enum logic [2:0] {ST_IDLE, ST_PREP, ST_SHIFT, ST_WAIT, ST_CAPTURE, ST_GAP} state_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/mram_host_shift_reg.sv
// mram_host_shift_reg: serial datapath of the MRAM host.
// Address and data registers are parallel-loaded and shifted out LSB first;
// the capture register shifts read bits in at the MSB so that after DATA_W
// shifts the first received bit sits at bit 0.
// Ports: clk, rst (async, active-low), load/addr/data (parallel load),
// shift_out (advance address/data), shift_in/sin (capture one read bit),
// addr_bit/data_bit (current serial bits), word (capture register).
module mram_host_shift_reg #(
  parameter int AW = 20,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          shift_out,
  input  logic          shift_in,
  input  logic          sin,
  output logic          addr_bit,
  output logic          data_bit,
  output logic [DW-1:0] word
);
  logic [AW-1:0] a_q;
  logic [DW-1:0] d_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      a_q <= '0;
      d_q <= '0;
      word <= '0;
    end else begin
      if (load) begin
        a_q <= addr;
        d_q <= data;
      end else if (shift_out) begin
        a_q <= {1'b0, a_q[AW-1:1]};
        d_q <= {1'b0, d_q[DW-1:1]};
      end
      if (shift_in) word <= {sin, word[DW-1:1]};
    end
  assign addr_bit = a_q[0];
  assign data_bit = d_q[0];
endmodule

// File: rtl/mram_serial_host.sv
// mram_serial_host: host-side initiator that serialises one read/write command to the MRAM front end.
// Ports: clk, rst (async, active-low); cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_data
// command handshake; done (1-cycle completion pulse), rd_data (last read word);
// read_write_sel (op code), addr_in/data_in (serial, LSB first), ser_data_out (serial read data in).
// Optional: define MRAM_HOST_STATS_EN to add 16-bit wr_count/rd_count completion counters.
// All outputs are registered: next-state values are computed combinationally and
// the outputs are registered from them, so each output lines up with its state's cycle.
module mram_serial_host
  import mram_host_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic [2:0]        read_write_sel,
  output logic              addr_in,
  output logic              data_in,
  input  logic              ser_data_out
`ifdef MRAM_HOST_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);
  localparam int CW = $clog2(max2(max2(ADDR_W, DATA_W), max2(RD_LAT, GAP_CYC)) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic op, op_n, accept, last, busy_n, shift_out, done_n, addr_bit, data_bit;
  logic [2:0] sel_n;
  logic [DATA_W-1:0] word, word_n;
  int len;
  assign accept = cmd_valid && cmd_ready;
  assign len = state == ST_SHIFT ? ADDR_W : state == ST_WAIT ? RD_LAT :
               state == ST_CAPTURE ? DATA_W : GAP_CYC;
  assign last = int'(cnt) == len - 1;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    op_n = op;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (accept) begin
          state_n = ST_PREP;
          op_n = cmd_write;
        end
      end
      ST_PREP: begin
        cnt_n = '0;
        state_n = ST_SHIFT;
      end
      ST_SHIFT: if (last) begin
        cnt_n = '0;
        state_n = op ? ST_GAP : (RD_LAT == 0 ? ST_CAPTURE : ST_WAIT);
      end
      ST_WAIT: if (last) begin
        cnt_n = '0;
        state_n = ST_CAPTURE;
      end
      ST_CAPTURE: if (last) begin
        cnt_n = '0;
        state_n = ST_GAP;
      end
      ST_GAP: if (last) begin
        cnt_n = '0;
        state_n = ST_IDLE;
      end
      default: begin
        cnt_n = '0;
        state_n = ST_IDLE;
      end
    endcase
    busy_n = state_n inside {ST_PREP, ST_SHIFT, ST_WAIT, ST_CAPTURE};
    sel_n = busy_n ? (op_n ? SEL_WRITE : SEL_READ) : SEL_IDLE;
    shift_out = state_n == ST_SHIFT;
    done_n = state_n == ST_GAP && int'(cnt_n) == GAP_CYC - 1;
    // With a single gap cycle, done coincides with the last capture edge,
    // so the incoming bit must be folded in here rather than read back later.
    word_n = state == ST_CAPTURE ? {ser_data_out, word[DATA_W-1:1]} : word;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      op <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      op <= op_n;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cmd_ready <= 1'b1;
      done <= 1'b0;
      rd_data <= '0;
      read_write_sel <= SEL_IDLE;
      addr_in <= 1'b0;
      data_in <= 1'b0;
    end else begin
      cmd_ready <= state_n == ST_IDLE;
      done <= done_n;
      read_write_sel <= sel_n;
      addr_in <= shift_out && addr_bit;
      data_in <= shift_out && data_bit;
      if (done_n && !op_n) rd_data <= word_n;
    end
`ifdef MRAM_HOST_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (done_n) begin
      if (op_n) wr_count <= wr_count + 16'd1;
      else rd_count <= rd_count + 16'd1;
    end
`endif
  mram_host_shift_reg #(.AW(ADDR_W), .DW(DATA_W)) u_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .addr     (cmd_addr),
    .data     (cmd_write ? cmd_data : '0),
    .shift_out(shift_out),
    .shift_in (state == ST_CAPTURE),
    .sin      (ser_data_out),
    .addr_bit (addr_bit),
    .data_bit (data_bit),
    .word     (word)
  );
endmodule

// File: tb/tb_mram_serial_host.sv
// tb_mram_serial_host: directed self-checking bench for mram_serial_host (default and RD_LAT=0/GAP_CYC=1 builds).
module tb_mram_serial_host;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, ser = 1'b0;
  logic [19:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic ready, done, addr_in, data_in;
  logic [15:0] rd_data;
  logic [2:0] sel;
  logic cmd_valid2 = 1'b0, cmd_write2 = 1'b0, ser2 = 1'b0;
  logic [19:0] cmd_addr2 = '0;
  logic [15:0] cmd_data2 = '0;
  logic ready2, done2, addr_in2, data_in2;
  logic [15:0] rd_data2;
  logic [2:0] sel2;
`ifdef MRAM_HOST_STATS_EN
  logic [15:0] wr_count, rd_count, wr_count2, rd_count2;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mram_serial_host dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .done(done), .rd_data(rd_data),
    .read_write_sel(sel), .addr_in(addr_in), .data_in(data_in), .ser_data_out(ser)
`ifdef MRAM_HOST_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  mram_serial_host #(.RD_LAT(0), .GAP_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(ready2), .cmd_write(cmd_write2),
    .cmd_addr(cmd_addr2), .cmd_data(cmd_data2), .done(done2), .rd_data(rd_data2),
    .read_write_sel(sel2), .addr_in(addr_in2), .data_in(data_in2), .ser_data_out(ser2)
`ifdef MRAM_HOST_STATS_EN
    , .wr_count(wr_count2), .rd_count(rd_count2)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks += 8;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0000", rd_data); end
    if (sel !== 3'b000) begin errors++; $display("FAIL reset_sel got %b exp 000", sel); end
    if (addr_in !== 1'b0) begin errors++; $display("FAIL reset_addr_in got %b exp 0", addr_in); end
    if (data_in !== 1'b0) begin errors++; $display("FAIL reset_data_in got %b exp 0", data_in); end
    if (ready2 !== 1'b1) begin errors++; $display("FAIL reset_ready2 got %b exp 1", ready2); end
    if (sel2 !== 3'b000) begin errors++; $display("FAIL reset_sel2 got %b exp 000", sel2); end
  endtask

  task automatic test_write;
    logic [19:0] a = 20'hA5A5A;
    logic [15:0] d = 16'h5555;
    logic [2:0] e_sel;
    logic e_addr, e_data;
    cmd_write = 1'b1; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      e_sel = n <= 21 ? 3'b011 : 3'b000;
      e_addr = (n >= 2 && n <= 21) ? a[n-2] : 1'b0;
      e_data = (n >= 2 && n <= 17) ? d[n-2] : 1'b0;
      checks += 6;
      if (sel !== e_sel) begin errors++; $display("FAIL wr_sel t0+%0d got %b exp %b", n, sel, e_sel); end
      if (addr_in !== e_addr) begin errors++; $display("FAIL wr_addr_in t0+%0d got %b exp %b", n, addr_in, e_addr); end
      if (data_in !== e_data) begin errors++; $display("FAIL wr_data_in t0+%0d got %b exp %b", n, data_in, e_data); end
      if (done !== (n == 23)) begin errors++; $display("FAIL wr_done t0+%0d got %b exp %b", n, done, n == 23); end
      if (ready !== (n == 24)) begin errors++; $display("FAIL wr_ready t0+%0d got %b exp %b", n, ready, n == 24); end
      if (rd_data !== 16'h0) begin errors++; $display("FAIL wr_rd_data t0+%0d got %h exp 0000", n, rd_data); end
      tick;
    end
  endtask

  task automatic test_read;
    logic [19:0] a = 20'h00003;
    logic [15:0] w = 16'hBEEF;
    logic [2:0] e_sel;
    logic e_addr;
    logic [15:0] e_rd;
    cmd_write = 1'b0; cmd_addr = a; cmd_data = 16'hFFFF; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    for (int n = 1; n <= 44; n++) begin
      ser = (n >= 26 && n <= 41) ? w[n-26] : 1'b1;
      e_sel = n <= 41 ? 3'b010 : 3'b000;
      e_addr = (n >= 2 && n <= 21) ? a[n-2] : 1'b0;
      e_rd = n >= 43 ? w : 16'h0;
      checks += 6;
      if (sel !== e_sel) begin errors++; $display("FAIL rd_sel t0+%0d got %b exp %b", n, sel, e_sel); end
      if (addr_in !== e_addr) begin errors++; $display("FAIL rd_addr_in t0+%0d got %b exp %b", n, addr_in, e_addr); end
      if (data_in !== 1'b0) begin errors++; $display("FAIL rd_data_in t0+%0d got %b exp 0", n, data_in); end
      if (done !== (n == 43)) begin errors++; $display("FAIL rd_done t0+%0d got %b exp %b", n, done, n == 43); end
      if (ready !== (n == 44)) begin errors++; $display("FAIL rd_ready t0+%0d got %b exp %b", n, ready, n == 44); end
      if (rd_data !== e_rd) begin errors++; $display("FAIL rd_rd_data t0+%0d got %h exp %h", n, rd_data, e_rd); end
      tick;
    end
    ser = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] w = 16'h1234;
    logic [15:0] e_rd;
    cmd_write = 1'b1; cmd_addr = 20'h12345; cmd_data = 16'hF00D; cmd_valid = 1'b1;
    tick;
    cmd_write = 1'b0; cmd_addr = 20'h0F0F0;
    for (int n = 1; n <= 24; n++) begin
      checks += 3;
      if (ready !== (n == 24)) begin errors++; $display("FAIL b2b_ready t0+%0d got %b exp %b", n, ready, n == 24); end
      if (done !== (n == 23)) begin errors++; $display("FAIL b2b_wr_done t0+%0d got %b exp %b", n, done, n == 23); end
      if (sel !== (n <= 21 ? 3'b011 : 3'b000)) begin errors++; $display("FAIL b2b_wr_sel t0+%0d got %b", n, sel); end
      tick;
    end
    cmd_valid = 1'b0;
    for (int m = 1; m <= 44; m++) begin
      ser = (m >= 26 && m <= 41) ? w[m-26] : 1'b0;
      e_rd = m >= 43 ? w : 16'hBEEF;
      checks += 4;
      if (sel !== (m <= 41 ? 3'b010 : 3'b000)) begin errors++; $display("FAIL b2b_rd_sel t1+%0d got %b", m, sel); end
      if (done !== (m == 43)) begin errors++; $display("FAIL b2b_rd_done t1+%0d got %b exp %b", m, done, m == 43); end
      if (ready !== (m == 44)) begin errors++; $display("FAIL b2b_rd_ready t1+%0d got %b exp %b", m, ready, m == 44); end
      if (rd_data !== e_rd) begin errors++; $display("FAIL b2b_rd_data t1+%0d got %h exp %h", m, rd_data, e_rd); end
      tick;
    end
    ser = 1'b0;
    checks++;
    if (sel !== 3'b000 || ready !== 1'b1) begin errors++; $display("FAIL b2b_no_reaccept sel %b ready %b exp 000 1", sel, ready); end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int done_at = 0;
    cmd_write = 1'b1; cmd_addr = 20'hFFFFF; cmd_data = 16'hFFFF; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    repeat (8) tick;
    checks += 2;
    if (addr_in !== 1'b1) begin errors++; $display("FAIL mid_bit7_addr got %b exp 1", addr_in); end
    if (sel !== 3'b011) begin errors++; $display("FAIL mid_bit7_sel got %b exp 011", sel); end
    rst = 1'b0;
    #1;
    checks += 6;
    if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", ready); end
    if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b exp 0", done); end
    if (rd_data !== 16'h0) begin errors++; $display("FAIL mid_rd_data got %h exp 0000", rd_data); end
    if (sel !== 3'b000) begin errors++; $display("FAIL mid_sel got %b exp 000", sel); end
    if (addr_in !== 1'b0) begin errors++; $display("FAIL mid_addr_in got %b exp 0", addr_in); end
    if (data_in !== 1'b0) begin errors++; $display("FAIL mid_data_in got %b exp 0", data_in); end
    tick;
    tick;
    rst = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (done === 1'b1 || sel !== 3'b000) dones++;
      tick;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL mid_no_done got %0d busy/done cycles exp 0", dones); end
    cmd_write = 1'b1; cmd_addr = 20'h00001; cmd_data = 16'h0001; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    for (int n = 1; n <= 30 && done_at == 0; n++) begin
      if (n == 2) begin
        checks++;
        if (addr_in !== 1'b1) begin errors++; $display("FAIL mid_after_addr0 got %b exp 1", addr_in); end
      end
      if (done === 1'b1) done_at = n;
      tick;
    end
    checks++;
    if (done_at != 23) begin errors++; $display("FAIL mid_after_done got t0+%0d exp t0+23", done_at); end
    tick;
  endtask

  task automatic test_params;
    logic [15:0] w = 16'hC3A5;
    logic [15:0] e_rd;
    cmd_write2 = 1'b0; cmd_addr2 = 20'h00005; cmd_valid2 = 1'b1;
    tick;
    cmd_valid2 = 1'b0;
    for (int n = 1; n <= 39; n++) begin
      ser2 = (n >= 22 && n <= 37) ? w[n-22] : 1'b1;
      e_rd = n >= 38 ? w : 16'h0;
      checks += 4;
      if (sel2 !== (n <= 37 ? 3'b010 : 3'b000)) begin errors++; $display("FAIL p_sel t0+%0d got %b", n, sel2); end
      if (done2 !== (n == 38)) begin errors++; $display("FAIL p_done t0+%0d got %b exp %b", n, done2, n == 38); end
      if (ready2 !== (n == 39)) begin errors++; $display("FAIL p_ready t0+%0d got %b exp %b", n, ready2, n == 39); end
      if (rd_data2 !== e_rd) begin errors++; $display("FAIL p_rd_data t0+%0d got %h exp %h", n, rd_data2, e_rd); end
      tick;
    end
    ser2 = 1'b0;
  endtask

`ifdef MRAM_HOST_STATS_EN
  task automatic test_stats;
    int waited;
    checks += 2;
    if (wr_count !== 16'd1) begin errors++; $display("FAIL st_wr_init got %0d exp 1", wr_count); end
    if (rd_count !== 16'd0) begin errors++; $display("FAIL st_rd_init got %0d exp 0", rd_count); end
    for (int i = 0; i < 4; i++) begin
      cmd_write = i[0]; cmd_addr = 20'(i); cmd_data = 16'h00AA; cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      waited = 0;
      while (done !== 1'b1 && waited < 60) begin tick; waited++; end
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL st_timeout cmd %0d got no done exp done", i); end
      tick;
    end
    checks += 2;
    if (wr_count !== 16'd3) begin errors++; $display("FAIL st_wr got %0d exp 3", wr_count); end
    if (rd_count !== 16'd2) begin errors++; $display("FAIL st_rd got %0d exp 2", rd_count); end
  endtask
`endif

  initial begin
    repeat (3) tick;
    rst = 1'b1;
    tick;
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_reset_mid;
    test_params;
`ifdef MRAM_HOST_STATS_EN
    test_stats;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
